adc_level_detector: RTL and testbench
=====================================

ADC_LEVEL_DETECTOR -- requirements
Module: adc_level_detector

Interface
REQ-001 Parameter: DATA_SIZE, 16, width of each signed two's-complement sample from the ADC controller.
REQ-002 Parameter: WINDOW_LOG2, 10, log2 of the number of valid samples in one measurement window.
REQ-003 Parameter: HIGH_THR, 16'd28000, peak magnitude at or above which a channel SHALL switch to low gain.
REQ-004 Parameter: LOW_THR, 16'd6000, peak magnitude below which a window counts as "quiet".
REQ-005 Parameter: HOLD_WINDOWS, 4, number of consecutive quiet windows needed before a channel switches to high gain.
REQ-006 Parameter: SETTLE_SAMPLES, 256, number of valid samples discarded after any gain change (relay settling).
REQ-007 Port: i_sys_clock  input  1  single clock for all logic; rising edge.
REQ-008 Port: i_reset  input  1  reset; synchronous and active-high.
REQ-009 Port: i_enable  input  1  measurement enable, driven high while IAGC status is SAMPLE.
REQ-010 Port: i_valid  input  1  qualifies i_data_ch1/i_data_ch2 in this cycle.
REQ-011 Port: i_data_ch1, i_data_ch2  input  DATA_SIZE each  signed samples from the ADC controller.
REQ-012 Port: o_peak_ch1, o_peak_ch2  output  DATA_SIZE each  unsigned peak magnitude of the last completed window.
REQ-013 Port: o_peak_valid  output  1  one-cycle pulse when o_peak_* and o_gain_* update.
REQ-014 Port: o_gain_ch1, o_gain_ch2  output  1 each  gain select, 1 = high gain, 0 = low gain; drives the controller's gain relays.
REQ-015 Port: o_settling  output  1  high while in SETTLE state.

Function
REQ-016 Magnitude SHALL be |sample| computed in DATA_SIZE bits, with the most negative value saturating to 2^(DATA_SIZE-1)-1.
REQ-017 States SHALL be IDLE, ACCUM, DECIDE, SETTLE; IDLE -> ACCUM on the edge where i_enable=1.
REQ-018 In ACCUM, each i_valid cycle SHALL update per-channel running peak = max(peak, magnitude) and increment a WINDOW_LOG2-bit sample counter.
REQ-019 The valid sample with counter = 2^WINDOW_LOG2-1 SHALL be included in the peak and SHALL cause ACCUM -> DECIDE on that edge; the counter wraps to 0.
REQ-020 DECIDE SHALL last exactly one cycle; i_valid samples in that cycle SHALL be dropped.
REQ-021 On the edge leaving DECIDE: o_peak_* <= running peaks, o_peak_valid <= 1 for one cycle, o_gain_* updated per REQ-022..024, running peaks cleared to 0.
REQ-022 Per channel, peak >= HIGH_THR with gain = 1 SHALL set gain to 0 and clear that channel's quiet counter.
REQ-023 Per channel, peak < LOW_THR SHALL increment the quiet counter (saturating at HOLD_WINDOWS); otherwise the counter SHALL clear to 0.
REQ-024 Per channel, gain = 0 with the incremented quiet count = HOLD_WINDOWS SHALL set gain to 1 and clear the counter; a peak >= HIGH_THR takes priority over a gain-up.
REQ-025 Channels SHALL decide independently; if either gain changed, DECIDE -> SETTLE, else DECIDE -> ACCUM.
REQ-026 SETTLE SHALL count SETTLE_SAMPLES valid samples without touching peaks, then -> ACCUM with the sample counter at 0.
REQ-027 i_enable = 0 in any non-IDLE state SHALL force IDLE on the next edge, clearing running peaks, sample/settle counters and quiet counters; o_gain_* and o_peak_* SHALL hold.
REQ-028 i_enable = 0 in the same cycle as a window-completing sample SHALL take precedence (-> IDLE, no DECIDE, no o_peak_valid).

Reset
REQ-029 i_reset = 1 on an edge SHALL force IDLE, all counters and peaks to 0, o_peak_* = 0, o_peak_valid = 0, o_gain_* = 0 (low gain, safe range), o_settling = 0; reset overrides all other inputs, including mid-window.

Structure
REQ-030 State encoding, default thresholds and the gain-select encoding (1 = high) SHALL live in the shared IAGC package alongside the IAGC status codes.
REQ-031 One sub-module adc_level_channel (magnitude, running peak, quiet counter, gain decision) SHALL be instantiated twice; the FSM and the window/settle counters stay in the top module.

Verification (bench uses WINDOW_LOG2=4, HOLD_WINDOWS=2, SETTLE_SAMPLES=8)
REQ-032 Reset, enable, 16 valid samples ch1 = ±1000 with one at -32768 -> o_peak_ch1 = 32767, o_peak_valid pulses once, o_gain_ch1 stays 0.
REQ-033 Two windows ch1 peak 500 -> o_gain_ch1 = 1 after the second o_peak_valid, o_settling high for exactly 8 valid samples.
REQ-034 Gain 1, window with ch1 sample 30000 -> o_gain_ch1 = 0 on the next o_peak_valid, ch2 unchanged, SETTLE entered.
REQ-035 i_valid toggling 1/0 -> o_peak_valid 16 valid samples after enable, never earlier; sample presented in DECIDE cycle excluded from the next peak.
REQ-036 Deassert i_enable at sample 10 of a window, then re-enable -> no o_peak_valid, next window counts from 0; i_reset mid-SETTLE -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/adc_level_detector_pkg.sv
// Shared IAGC definitions: controller status codes, level-detector state
// encoding, default thresholds and the gain-select encoding.
package adc_level_detector_pkg;

    typedef enum logic [1:0] {
        IAGC_STATUS_IDLE   = 2'd0,
        IAGC_STATUS_SAMPLE = 2'd1,
        IAGC_STATUS_ADJUST = 2'd2,
        IAGC_STATUS_FAULT  = 2'd3
    } iagc_status_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DECIDE = 2'd2,
        ST_SETTLE = 2'd3
    } det_state_t;

    localparam int unsigned DEFAULT_DATA_SIZE      = 16;
    localparam int unsigned DEFAULT_WINDOW_LOG2    = 10;
    localparam int unsigned DEFAULT_HIGH_THR       = 28000;
    localparam int unsigned DEFAULT_LOW_THR        = 6000;
    localparam int unsigned DEFAULT_HOLD_WINDOWS   = 4;
    localparam int unsigned DEFAULT_SETTLE_SAMPLES = 256;

    // Relay drive level: 1 selects the high-gain (sensitive) range.
    localparam logic GAIN_HIGH = 1'b1;
    localparam logic GAIN_LOW  = 1'b0;

endpackage

// File: rtl/adc_level_channel.sv
// One ADC channel: magnitude, running window peak, quiet-window counter
// and the per-window gain decision.
module adc_level_channel
    import adc_level_detector_pkg::*;
#(
    parameter int unsigned DATA_SIZE    = DEFAULT_DATA_SIZE,
    parameter int unsigned HIGH_THR     = DEFAULT_HIGH_THR,
    parameter int unsigned LOW_THR      = DEFAULT_LOW_THR,
    parameter int unsigned HOLD_WINDOWS = DEFAULT_HOLD_WINDOWS
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 sample_en,
    input  logic                 decide_en,
    input  logic                 clear,
    input  logic [DATA_SIZE-1:0] data,
    output logic [DATA_SIZE-1:0] peak,
    output logic                 gain,
    output logic                 gain_change
);

    localparam int unsigned          QW       = $clog2(HOLD_WINDOWS + 1);
    localparam logic [QW-1:0]        HOLD_Q   = QW'(HOLD_WINDOWS);
    localparam logic [DATA_SIZE-1:0] HIGH_T   = DATA_SIZE'(HIGH_THR);
    localparam logic [DATA_SIZE-1:0] LOW_T    = DATA_SIZE'(LOW_THR);
    localparam logic [DATA_SIZE-1:0] MOST_NEG = {1'b1, {(DATA_SIZE-1){1'b0}}};
    localparam logic [DATA_SIZE-1:0] MAX_POS  = {1'b0, {(DATA_SIZE-1){1'b1}}};

    logic [DATA_SIZE-1:0] mag;
    logic [DATA_SIZE-1:0] run_peak_reg;
    logic [DATA_SIZE-1:0] peak_reg;
    logic [QW-1:0]        quiet_reg;
    logic [QW-1:0]        quiet_inc;
    logic                 gain_reg;
    logic                 go_low;
    logic                 go_high;

    // The most negative code has no positive twin, so it saturates.
    always_comb begin
        if (data == MOST_NEG) begin
            mag = MAX_POS;
        end else if (data[DATA_SIZE-1]) begin
            mag = ~data + DATA_SIZE'(1);
        end else begin
            mag = data;
        end
    end

    always_comb begin
        quiet_inc = '0;
        if (run_peak_reg < LOW_T) begin
            quiet_inc = (quiet_reg >= HOLD_Q) ? HOLD_Q : quiet_reg + QW'(1);
        end
        go_low  = (gain_reg == GAIN_HIGH) && (run_peak_reg >= HIGH_T);
        go_high = (gain_reg == GAIN_LOW) && (quiet_inc == HOLD_Q) && (run_peak_reg < HIGH_T);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            run_peak_reg <= '0;
            peak_reg     <= '0;
            quiet_reg    <= '0;
            gain_reg     <= GAIN_LOW;
        end else if (clear) begin
            run_peak_reg <= '0;
            quiet_reg    <= '0;
        end else if (decide_en) begin
            peak_reg     <= run_peak_reg;
            run_peak_reg <= '0;
            if (go_low) begin
                gain_reg  <= GAIN_LOW;
                quiet_reg <= '0;
            end else if (go_high) begin
                gain_reg  <= GAIN_HIGH;
                quiet_reg <= '0;
            end else begin
                quiet_reg <= quiet_inc;
            end
        end else if (sample_en && (mag > run_peak_reg)) begin
            run_peak_reg <= mag;
        end
    end

    assign peak        = peak_reg;
    assign gain        = gain_reg;
    assign gain_change = go_low | go_high;

endmodule

// File: rtl/adc_level_detector.sv
// Two-channel peak level detector driving the ADC gain relays: measures a
// window of samples, decides gain per channel, then waits for relays to settle.
module adc_level_detector
    import adc_level_detector_pkg::*;
#(
    parameter int unsigned DATA_SIZE      = DEFAULT_DATA_SIZE,
    parameter int unsigned WINDOW_LOG2    = DEFAULT_WINDOW_LOG2,
    parameter int unsigned HIGH_THR       = DEFAULT_HIGH_THR,
    parameter int unsigned LOW_THR        = DEFAULT_LOW_THR,
    parameter int unsigned HOLD_WINDOWS   = DEFAULT_HOLD_WINDOWS,
    parameter int unsigned SETTLE_SAMPLES = DEFAULT_SETTLE_SAMPLES
) (
    input  logic                 i_sys_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_valid,
    input  logic [DATA_SIZE-1:0] i_data_ch1,
    input  logic [DATA_SIZE-1:0] i_data_ch2,
    output logic [DATA_SIZE-1:0] o_peak_ch1,
    output logic [DATA_SIZE-1:0] o_peak_ch2,
    output logic                 o_peak_valid,
    output logic                 o_gain_ch1,
    output logic                 o_gain_ch2,
    output logic                 o_settling
);

    localparam int unsigned   SW          = $clog2(SETTLE_SAMPLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_SAMPLES - 1);

    det_state_t             state_reg;
    det_state_t             state_next;
    logic [WINDOW_LOG2-1:0] sample_cnt_reg;
    logic [SW-1:0]          settle_cnt_reg;
    logic                   peak_valid_reg;

    logic                   sample_en;
    logic                   decide_fire;
    logic                   clear_run;
    logic                   window_done;
    logic                   settle_done;

    logic [DATA_SIZE-1:0]   ch_data [2];
    logic [DATA_SIZE-1:0]   ch_peak [2];
    logic [1:0]             ch_gain;
    logic [1:0]             ch_change;

    assign ch_data[0] = i_data_ch1;
    assign ch_data[1] = i_data_ch2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            adc_level_channel #(
                .DATA_SIZE    (DATA_SIZE),
                .HIGH_THR     (HIGH_THR),
                .LOW_THR      (LOW_THR),
                .HOLD_WINDOWS (HOLD_WINDOWS)
            ) u_ch (
                .clk         (i_sys_clock),
                .srst        (i_reset),
                .sample_en   (sample_en),
                .decide_en   (decide_fire),
                .clear       (clear_run),
                .data        (ch_data[gi]),
                .peak        (ch_peak[gi]),
                .gain        (ch_gain[gi]),
                .gain_change (ch_change[gi])
            );
        end
    endgenerate

    always_ff @(posedge i_sys_clock) begin
        if (i_reset) begin
            state_reg      <= ST_IDLE;
            sample_cnt_reg <= '0;
            settle_cnt_reg <= '0;
            peak_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            peak_valid_reg <= decide_fire;
            if (clear_run) begin
                sample_cnt_reg <= '0;
                settle_cnt_reg <= '0;
            end else begin
                // Window counter wraps naturally on the window-completing sample.
                if (sample_en) begin
                    sample_cnt_reg <= sample_cnt_reg + WINDOW_LOG2'(1);
                end
                if ((state_reg == ST_SETTLE) && i_valid) begin
                    settle_cnt_reg <= settle_done ? '0 : settle_cnt_reg + SW'(1);
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        if ((state_reg != ST_IDLE) && !i_enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:   if (i_enable) state_next = ST_ACCUM;
                ST_ACCUM:  if (window_done) state_next = ST_DECIDE;
                ST_DECIDE: state_next = (|ch_change) ? ST_SETTLE : ST_ACCUM;
                ST_SETTLE: if (settle_done) state_next = ST_ACCUM;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sample_en   = (state_reg == ST_ACCUM) && i_enable && i_valid;
        window_done = sample_en && (sample_cnt_reg == '1);
        settle_done = (state_reg == ST_SETTLE) && i_valid && (settle_cnt_reg == SETTLE_LAST);
        decide_fire = (state_reg == ST_DECIDE) && i_enable;
        clear_run   = (state_reg != ST_IDLE) && !i_enable;
        o_settling  = (state_reg == ST_SETTLE);
    end

    assign o_peak_ch1   = ch_peak[0];
    assign o_peak_ch2   = ch_peak[1];
    assign o_gain_ch1   = ch_gain[0];
    assign o_gain_ch2   = ch_gain[1];
    assign o_peak_valid = peak_valid_reg;

endmodule

// File: tb/tb_adc_level_detector.sv
// Randomized scoreboard bench for adc_level_detector against a behavioural
// model of windows, gain decisions, settling and enable/reset handling.
module tb_adc_level_detector;

    localparam int DW     = 16;
    localparam int WL     = 4;
    localparam int WIN    = 16;
    localparam int HOLD   = 2;
    localparam int SETTLE = 8;
    localparam int HIGH   = 28000;
    localparam int LOW    = 6000;

    localparam int M_IDLE = 0;
    localparam int M_ACC  = 1;
    localparam int M_DEC  = 2;
    localparam int M_SET  = 3;

    logic          clk = 1'b0;
    logic          rst, en, v;
    logic [DW-1:0] d1, d2;
    logic [DW-1:0] o_peak_ch1, o_peak_ch2;
    logic          o_peak_valid, o_gain_ch1, o_gain_ch2, o_settling;

    always #5 clk = ~clk;

    adc_level_detector #(
        .DATA_SIZE      (DW),
        .WINDOW_LOG2    (WL),
        .HIGH_THR       (HIGH),
        .LOW_THR        (LOW),
        .HOLD_WINDOWS   (HOLD),
        .SETTLE_SAMPLES (SETTLE)
    ) dut (
        .i_sys_clock  (clk),
        .i_reset      (rst),
        .i_enable     (en),
        .i_valid      (v),
        .i_data_ch1   (d1),
        .i_data_ch2   (d2),
        .o_peak_ch1   (o_peak_ch1),
        .o_peak_ch2   (o_peak_ch2),
        .o_peak_valid (o_peak_valid),
        .o_gain_ch1   (o_gain_ch1),
        .o_gain_ch2   (o_gain_ch2),
        .o_settling   (o_settling)
    );

    typedef struct { int pk1; int pk2; bit g1; bit g2; } exp_t;
    exp_t sbq[$];

    int checks = 0, errors = 0, pv_count = 0, settle_seen = 0;
    int m_mode, m_cnt, m_scnt, m_run1, m_run2, m_q1, m_q2, m_pk1, m_pk2;
    bit m_g1, m_g2, m_pv, armed = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, req);
        end
    endfunction

    function automatic int mag(input logic [DW-1:0] s);
        int x;
        x = int'($signed(s));
        if (x == -32768) return 32767;
        return (x < 0) ? -x : x;
    endfunction

    function automatic int rnd(input int lo, input int hi);
        int m;
        m = int'($urandom_range(hi, lo));
        return ($urandom_range(1) == 1) ? m : -m;
    endfunction

    task automatic ch_decide(input int pk, input bit g_in, input int q_in,
                             output bit g_out, output int q_out);
        int qi;
        qi    = (pk < LOW) ? ((q_in + 1 > HOLD) ? HOLD : q_in + 1) : 0;
        g_out = g_in;
        q_out = qi;
        if (pk >= HIGH && g_in) begin
            g_out = 1'b0;
            q_out = 0;
        end else if (!g_in && qi == HOLD) begin
            g_out = 1'b1;
            q_out = 0;
        end
    endtask

    // Behavioural model: advances one clock edge using the inputs now applied.
    task automatic model_edge();
        bit   n1, n2;
        exp_t e;
        m_pv = 1'b0;
        if (rst) begin
            m_mode = M_IDLE; m_cnt = 0; m_scnt = 0; m_run1 = 0; m_run2 = 0;
            m_q1 = 0; m_q2 = 0; m_pk1 = 0; m_pk2 = 0; m_g1 = 0; m_g2 = 0;
            sbq.delete();
        end else if (m_mode != M_IDLE && !en) begin
            m_mode = M_IDLE; m_cnt = 0; m_scnt = 0; m_run1 = 0; m_run2 = 0;
            m_q1 = 0; m_q2 = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (en) m_mode = M_ACC;
                M_ACC: if (v) begin
                    if (mag(d1) > m_run1) m_run1 = mag(d1);
                    if (mag(d2) > m_run2) m_run2 = mag(d2);
                    if (m_cnt == WIN - 1) begin
                        m_cnt  = 0;
                        m_mode = M_DEC;
                    end else begin
                        m_cnt++;
                    end
                end
                M_DEC: begin
                    ch_decide(m_run1, m_g1, m_q1, n1, m_q1);
                    ch_decide(m_run2, m_g2, m_q2, n2, m_q2);
                    m_mode = (n1 != m_g1 || n2 != m_g2) ? M_SET : M_ACC;
                    m_g1 = n1; m_g2 = n2;
                    m_pk1 = m_run1; m_pk2 = m_run2;
                    m_run1 = 0; m_run2 = 0;
                    m_pv = 1'b1;
                    e.pk1 = m_pk1; e.pk2 = m_pk2; e.g1 = m_g1; e.g2 = m_g2;
                    sbq.push_back(e);
                end
                default: if (v) begin
                    m_scnt++;
                    if (m_scnt == SETTLE) begin
                        m_scnt = 0;
                        m_mode = M_ACC;
                    end
                end
            endcase
        end
    endtask

    task automatic step(input bit r, input bit e, input bit vv, input int a, input int b);
        rst = r; en = e; v = vv; d1 = DW'(a); d2 = DW'(b);
        @(posedge clk);
        model_edge();
        if (r) armed = 1'b1;
        #1;
    endtask

    task automatic settle_time();
        @(negedge clk);
        #1;
    endtask

    // Issue n valid samples (optionally with idle cycles between) plus an optional spike on ch1.
    task automatic feed(input int n, input int lo1, input int hi1, input int lo2, input int hi2,
                        input bit toggle, input int spike_idx, input int spike_val);
        int sent;
        int a, b;
        bit vv;
        sent = 0;
        vv   = 1'b1;
        while (sent < n) begin
            if (vv) begin
                a = (sent == spike_idx) ? spike_val : rnd(lo1, hi1);
                b = rnd(lo2, hi2);
                step(0, 1, 1, a, b);
                sent++;
            end else begin
                step(0, 1, 0, rnd(20000, 32767), rnd(20000, 32767));
            end
            if (toggle) vv = ~vv;
        end
    endtask

    task automatic drain_settle();
        int k;
        k = 0;
        settle_seen = 0;
        while (o_settling && k < 100) begin
            step(0, 1, k[0], rnd(20000, 32767), rnd(20000, 32767));
            k++;
        end
        chk("settle_samples", settle_seen, SETTLE);
    endtask

    // Monitor: per-cycle output comparison plus scoreboard pop on each peak pulse.
    always @(negedge clk) begin
        exp_t e;
        if (armed) begin
            chk("peak_valid", o_peak_valid, m_pv);
            chk("peak_ch1", o_peak_ch1, m_pk1);
            chk("peak_ch2", o_peak_ch2, m_pk2);
            chk("gain_ch1", o_gain_ch1, m_g1);
            chk("gain_ch2", o_gain_ch2, m_g2);
            chk("settling", o_settling, m_mode == M_SET);
            if (o_peak_valid === 1'b1) begin
                pv_count++;
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_pulse", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_peak1", o_peak_ch1, e.pk1);
                    chk("sb_peak2", o_peak_ch2, e.pk2);
                    chk("sb_gain1", o_gain_ch1, e.g1);
                    chk("sb_gain2", o_gain_ch2, e.g2);
                end
            end else if (sbq.size() != 0) begin
                chk("sb_missed_pulse", sbq.size(), 0);
                sbq.delete();
            end
            if (o_settling && v) settle_seen++;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout t=%0t actual=running required=finished", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int snap;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        settle_time();
        chk("rst_peak1", o_peak_ch1, 0);
        chk("rst_gain1", o_gain_ch1, 0);
        chk("rst_settling", o_settling, 0);

        // Window with a saturating -32768 sample on ch1.
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < WIN; i++) begin
            step(0, 1, 1, (i == 7) ? -32768 : ((i % 2 == 1) ? 1000 : -1000), rnd(7000, 20000));
        end
        step(0, 1, 0, 0, 0);
        settle_time();
        chk("s1_peak1", o_peak_ch1, 32767);
        chk("s1_pv_count", pv_count, 1);
        chk("s1_gain1", o_gain_ch1, 0);

        // Two quiet windows on ch1 raise its gain, then settle.
        feed(WIN, 0, 500, 7000, 20000, 0, 3, 500);
        step(0, 1, 0, 0, 0);
        feed(WIN, 0, 500, 7000, 20000, 0, 9, -500);
        step(0, 1, 0, 0, 0);
        chk("s2_peak1", o_peak_ch1, 500);
        chk("s2_gain1", o_gain_ch1, 1);
        chk("s2_settling", o_settling, 1);
        drain_settle();

        // A loud sample drops ch1 back to low gain; ch2 untouched.
        feed(WIN, 0, 2000, 7000, 20000, 0, 5, 30000);
        step(0, 1, 0, 0, 0);
        chk("s3_gain1", o_gain_ch1, 0);
        chk("s3_gain2", o_gain_ch2, 0);
        chk("s3_settling", o_settling, 1);
        drain_settle();

        // Toggling valid from enable; a sample in the DECIDE cycle is dropped.
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        snap = pv_count;
        feed(WIN, 0, 2000, 0, 2000, 1, -1, 0);
        settle_time();
        chk("s4_no_early_pv", pv_count, snap);
        step(0, 1, 1, 25000, 25000);
        feed(WIN, 0, 2000, 0, 2000, 1, -1, 0);
        step(0, 1, 0, 0, 0);
        chk("s4_excl1", o_peak_ch1 <= 2000, 1);
        chk("s4_excl2", o_peak_ch2 <= 2000, 1);
        chk("s4_gain1", o_gain_ch1, 1);
        drain_settle();

        // Enable drop mid-window, then a window-completing sample with enable low.
        feed(10, 7000, 20000, 7000, 20000, 0, -1, 0);
        snap = pv_count;
        step(0, 0, 1, 32000, 32000);
        step(0, 1, 0, 0, 0);
        feed(WIN, 7000, 20000, 7000, 20000, 0, -1, 0);
        step(0, 1, 0, 0, 0);
        settle_time();
        chk("s5_one_pv", pv_count, snap + 1);
        feed(WIN - 1, 7000, 20000, 7000, 20000, 0, -1, 0);
        step(0, 0, 1, 32000, 32000);
        step(0, 0, 0, 0, 0);
        settle_time();
        chk("s5_no_pv", pv_count, snap + 1);

        // Reset in the middle of SETTLE.
        step(0, 1, 0, 0, 0);
        feed(WIN, 7000, 20000, 7000, 20000, 0, 2, 30000);
        step(0, 1, 0, 0, 0);
        chk("s6_settling", o_settling, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 100, 100);
        step(1, 1, 1, 100, 100);
        chk("s6_peak1", o_peak_ch1, 0);
        chk("s6_peak2", o_peak_ch2, 0);
        chk("s6_gain1", o_gain_ch1, 0);
        chk("s6_gain2", o_gain_ch2, 0);
        chk("s6_settling", o_settling, 0);
        chk("s6_pv", o_peak_valid, 0);

        // Randomized traffic with shifting amplitude bands.
        begin
            int amp1, amp2;
            amp1 = 2000; amp2 = 2000;
            for (int i = 0; i < 900; i++) begin
                if (i % 40 == 0) begin
                    amp1 = ($urandom_range(2) == 0) ? 2000 : (($urandom_range(1) == 0) ? 15000 : 32768);
                    amp2 = ($urandom_range(2) == 0) ? 2000 : (($urandom_range(1) == 0) ? 15000 : 32768);
                end
                step(0, $urandom_range(199) != 0, $urandom_range(1) == 1, rnd(0, amp1), rnd(0, amp2));
            end
        end

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        settle_time();
        chk("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
